motors_telemetry_collector: RTL and testbench

// - Return path from the four bidirectional-DShot motor channels to the PS register bank.
// - Accepts raw 16-bit telemetry frames from the per-motor decoders and checks their CRC.
// - Decodes each frame to an eRPM period, tracks per-motor freshness and error counts.
// - Presents PS-readable status words that are updated atomically on a snapshot request.

---
 rtl/motors_pkg.sv | 44 ++++
 rtl/dshot_tlm_decode.sv | 17 +
 rtl/motors_telemetry_collector.sv | 173 +++++++++++++++++
 tb/tb_motors_telemetry_collector.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/motors_pkg.sv
// rtl/motors_pkg.sv - shared constants and helpers for the motor telemetry return path
package motors_pkg;

    localparam int NUM_MOTORS = 4;
    localparam int IDX_W      = 2;

    // Raw telemetry frame fields
    localparam int FRM_VAL_MSB = 15;
    localparam int FRM_VAL_LSB = 4;
    localparam int FRM_CRC_MSB = 3;
    localparam int FRM_CRC_LSB = 0;

    // Fields of the 12-bit value
    localparam int VAL_EXP_MSB  = 11;
    localparam int VAL_EXP_LSB  = 9;
    localparam int VAL_MANT_MSB = 8;
    localparam int VAL_MANT_LSB = 0;

    // Status word bit positions
    localparam int ST_PERIOD_MSB = 15;
    localparam int ST_VALID_BIT  = 16;
    localparam int ST_STALE_BIT  = 17;
    localparam int ST_ERR_LSB    = 24;

    // One decode-stage result headed for writeback
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic             crc_ok;
        logic [15:0]      period;
    } dec_result_t;

    function automatic logic [31:0] status_word(input logic [15:0] period, input logic valid,
                                                input logic stale, input logic [7:0] err);
        logic [31:0] w;
        w                      = '0;
        w[ST_PERIOD_MSB:0]     = period;
        w[ST_VALID_BIT]        = valid;
        w[ST_STALE_BIT]        = stale;
        w[31:ST_ERR_LSB]       = err;
        return w;
    endfunction

endpackage

// File: rtl/dshot_tlm_decode.sv
// rtl/dshot_tlm_decode.sv - combinational CRC check and exponent/mantissa to period conversion
module dshot_tlm_decode
    import motors_pkg::*;
(
    input  logic [15:0] frame,
    output logic        crc_ok,
    output logic [15:0] period
);

    logic [11:0] v;

    assign v      = frame[FRM_VAL_MSB:FRM_VAL_LSB];
    assign crc_ok = (frame[FRM_CRC_MSB:FRM_CRC_LSB] == ~(v[3:0] ^ v[7:4] ^ v[11:8]));
    // Largest mantissa shifted by the largest exponent is 0xFF80, so 16 bits never overflow
    assign period = {7'b0, v[VAL_MANT_MSB:VAL_MANT_LSB]} << v[VAL_EXP_MSB:VAL_EXP_LSB];

endmodule

// File: rtl/motors_telemetry_collector.sv
// rtl/motors_telemetry_collector.sv - telemetry capture, arbitration, decode and snapshot registers (option: MOTORS_TLM_TIMEOUT_EN)
module motors_telemetry_collector
    import motors_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ERRCNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  tlm_valid_i,
    input  logic [15:0] tlm_data_0,
    input  logic [15:0] tlm_data_1,
    input  logic [15:0] tlm_data_2,
    input  logic [15:0] tlm_data_3,
    input  logic        snap_req,
    output logic        snap_ack,
    output logic [31:0] reg_09,
    output logic [31:0] reg_0A,
    output logic [31:0] reg_0B,
    output logic [31:0] reg_0C,
    output logic [31:0] reg_0D
);

    logic [15:0]           in_frame   [NUM_MOTORS];
    logic [15:0]           pend_frame [NUM_MOTORS];
    logic [NUM_MOTORS-1:0] pend;
    logic [IDX_W-1:0]      last_grant, gnt_idx, cand;
    logic                  gnt_any;
    logic                  dec_crc_ok;
    logic [15:0]           dec_period;
    dec_result_t           dec;

    logic [15:0]           live_period [NUM_MOTORS];
    logic [15:0]           period_nxt  [NUM_MOTORS];
    logic [ERRCNT_W-1:0]   err_cnt     [NUM_MOTORS];
    logic [ERRCNT_W-1:0]   err_nxt     [NUM_MOTORS];
    logic [NUM_MOTORS-1:0] live_valid, valid_nxt, live_stale, stale_nxt;
    logic [31:0]           stat_nxt    [NUM_MOTORS];

`ifdef MOTORS_TLM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_cnt [NUM_MOTORS];
    logic [TMO_W-1:0] tmo_nxt [NUM_MOTORS];
`endif

    assign in_frame[0] = tlm_data_0;
    assign in_frame[1] = tlm_data_1;
    assign in_frame[2] = tlm_data_2;
    assign in_frame[3] = tlm_data_3;

    // Round-robin pick of one pending motor, searching from just after the last grant
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_MOTORS; k++) begin
            cand = last_grant + IDX_W'(k);
            if (!gnt_any && pend[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // One-deep pending buffers: newest frame wins, a same-cycle strobe survives its own grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= '0;
            last_grant <= IDX_W'(NUM_MOTORS - 1);
            for (int k = 0; k < NUM_MOTORS; k++) pend_frame[k] <= '0;
        end else begin
            if (gnt_any) last_grant <= gnt_idx;
            for (int k = 0; k < NUM_MOTORS; k++) begin
                if (tlm_valid_i[k]) pend_frame[k] <= in_frame[k];
                pend[k] <= tlm_valid_i[k] | (pend[k] & ~(gnt_any && (gnt_idx == IDX_W'(k))));
            end
        end
    end

    dshot_tlm_decode u_decode (
        .frame  (pend_frame[gnt_idx]),
        .crc_ok (dec_crc_ok),
        .period (dec_period)
    );

    // Decode stage register shared by all motors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dec <= '0;
        else     dec <= '{vld: gnt_any, idx: gnt_idx, crc_ok: dec_crc_ok, period: dec_period};
    end

    // Writeback: next live state, also what a same-cycle snapshot captures
    always_comb begin
        valid_nxt = live_valid;
        stale_nxt = live_stale;
        for (int n = 0; n < NUM_MOTORS; n++) begin
            period_nxt[n] = live_period[n];
            err_nxt[n]    = err_cnt[n];
`ifdef MOTORS_TLM_TIMEOUT_EN
            tmo_nxt[n] = tmo_cnt[n];
            if (tmo_cnt[n] != TMO_MAX) begin
                tmo_nxt[n] = tmo_cnt[n] + TMO_W'(1);
                if (tmo_cnt[n] == TMO_LAST) begin
                    stale_nxt[n] = 1'b1;
                    valid_nxt[n] = 1'b0;
                end
            end
`endif
            if (dec.vld && (dec.idx == IDX_W'(n))) begin
                if (dec.crc_ok) begin
                    period_nxt[n] = dec.period;
                    valid_nxt[n]  = 1'b1;
                    stale_nxt[n]  = 1'b0;
`ifdef MOTORS_TLM_TIMEOUT_EN
                    tmo_nxt[n]    = '0;
`endif
                end else if (err_cnt[n] != '1) begin
                    err_nxt[n] = err_cnt[n] + ERRCNT_W'(1);
                end
            end
            stat_nxt[n] = status_word(period_nxt[n], valid_nxt[n], stale_nxt[n], 8'(err_nxt[n]));
        end
    end

    // Live per-motor state; stale stays set until the first good frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_valid <= '0;
            live_stale <= '1;
            for (int n = 0; n < NUM_MOTORS; n++) begin
                live_period[n] <= '0;
                err_cnt[n]     <= '0;
`ifdef MOTORS_TLM_TIMEOUT_EN
                tmo_cnt[n]     <= '0;
`endif
            end
        end else begin
            live_valid <= valid_nxt;
            live_stale <= stale_nxt;
            for (int n = 0; n < NUM_MOTORS; n++) begin
                live_period[n] <= period_nxt[n];
                err_cnt[n]     <= err_nxt[n];
`ifdef MOTORS_TLM_TIMEOUT_EN
                tmo_cnt[n]     <= tmo_nxt[n];
`endif
            end
        end
    end

    // Snapshot registers: all five words update together, ack follows one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_ack <= 1'b0;
            reg_09   <= '0;
            reg_0A   <= '0;
            reg_0B   <= '0;
            reg_0C   <= '0;
            reg_0D   <= '0;
        end else begin
            snap_ack <= snap_req;
            if (snap_req) begin
                reg_09 <= stat_nxt[0];
                reg_0A <= stat_nxt[1];
                reg_0B <= stat_nxt[2];
                reg_0C <= stat_nxt[3];
                reg_0D <= {8'h00, stale_nxt, valid_nxt, reg_0D[15:0] + 16'd1};
            end
        end
    end

endmodule

// File: tb/tb_motors_telemetry_collector.sv
// tb/tb_motors_telemetry_collector.sv - randomized and directed bench for motors_telemetry_collector
module tb_motors_telemetry_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  tlm_valid_i;
    logic [15:0] tdata [4];
    logic        snap_req;
    logic        snap_ack;
    logic [31:0] reg_09, reg_0A, reg_0B, reg_0C, reg_0D;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_snaps = 0;

`ifdef MOTORS_TLM_TIMEOUT_EN
    localparam logic [31:0] ST_MASK  = 32'hFFFC_FFFF;
    localparam logic [31:0] CTL_MASK = 32'hFF00_FFFF;
`else
    localparam logic [31:0] ST_MASK  = 32'hFFFF_FFFF;
    localparam logic [31:0] CTL_MASK = 32'hFFFF_FFFF;
`endif

    always #5 clk = ~clk;

    motors_telemetry_collector #(.TIMEOUT_CYCLES(50), .ERRCNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tlm_valid_i (tlm_valid_i),
        .tlm_data_0  (tdata[0]),
        .tlm_data_1  (tdata[1]),
        .tlm_data_2  (tdata[2]),
        .tlm_data_3  (tdata[3]),
        .snap_req    (snap_req),
        .snap_ack    (snap_ack),
        .reg_09      (reg_09),
        .reg_0A      (reg_0A),
        .reg_0B      (reg_0B),
        .reg_0C      (reg_0C),
        .reg_0D      (reg_0D)
    );

    function automatic logic [15:0] mk_good(input int v);
        int c;
        c = ((v & 15) ^ ((v >> 4) & 15) ^ ((v >> 8) & 15)) ^ 15;
        return 16'(((v & 12'hFFF) << 4) | c);
    endfunction

    function automatic int period_of(input int v);
        return (v & 511) * (1 << ((v >> 9) & 7));
    endfunction

    function automatic logic [31:0] get_reg(input int n);
        case (n)
            0:       return reg_09;
            1:       return reg_0A;
            2:       return reg_0B;
            3:       return reg_0C;
            default: return reg_0D;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] m);
        tlm_valid_i = m;
        @(posedge clk); #1;
        tlm_valid_i = '0;
    endtask

    task automatic snap();
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
        exp_snaps++;
    endtask

    task automatic do_reset();
        rst = 1'b1; tlm_valid_i = '0; snap_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_snaps = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tlm_valid_i = '0; snap_req = 1'b0;
        for (int n = 0; n < 4; n++) tdata[n] = '0;
        repeat (2) @(posedge clk); #1;
        for (int n = 0; n < 5; n++) begin
            n_chk++; if (get_reg(n) !== 32'h0) $display("FAIL reset_reg%0d got %h want 00000000", n, get_reg(n)); else n_pass++;
        end
        n_chk++; if (snap_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", snap_ack); else n_pass++;
        rst = 1'b0; exp_snaps = 0;
        snap();
        n_chk++; if (snap_ack !== 1'b1) $display("FAIL reset_snap_ack got %b want 1", snap_ack); else n_pass++;
        for (int n = 0; n < 4; n++) begin
            n_chk++; if (get_reg(n) !== 32'h0002_0000) $display("FAIL reset_status%0d got %h want 00020000", n, get_reg(n)); else n_pass++;
        end
        n_chk++; if (reg_0D !== 32'h00F0_0001) $display("FAIL reset_ctl got %h want 00f00001", reg_0D); else n_pass++;
    endtask

    task automatic test_latency_m0();
        tdata[0] = 16'h0A50;
        strobe(4'b0001);
        idle(1);
        snap();
        n_chk++; if (snap_ack !== 1'b1) $display("FAIL m0_ack got %b want 1", snap_ack); else n_pass++;
        n_chk++; if (reg_09 !== 32'h0001_00A5) $display("FAIL m0_status got %h want 000100a5", reg_09); else n_pass++;
        n_chk++; if (reg_0D !== {8'h00, 4'hE, 4'h1, 16'(exp_snaps)})
            $display("FAIL m0_ctl got %h want %h", reg_0D, {8'h00, 4'hE, 4'h1, 16'(exp_snaps)}); else n_pass++;
        idle(1);
        n_chk++; if (snap_ack !== 1'b0) $display("FAIL m0_ack_drop got %b want 0", snap_ack); else n_pass++;
    endtask

    task automatic test_crc_err();
        tdata[2] = 16'h3C88;
        strobe(4'b0100); idle(5); snap();
        n_chk++; if (reg_0B[16:0] !== {1'b1, 16'd912}) $display("FAIL m2_good got %h want %h", reg_0B[16:0], {1'b1, 16'd912}); else n_pass++;
        tdata[2] = 16'h3C80;
        strobe(4'b0100); idle(5); snap();
        n_chk++; if ((reg_0B & ST_MASK) !== (32'h0101_0390 & ST_MASK)) $display("FAIL m2_bad1 got %h want 01010390", reg_0B); else n_pass++;
        for (int i = 0; i < 300; i++) begin
            strobe(4'b0100); idle(1);
        end
        idle(6); snap();
        n_chk++; if ({reg_0B[31:24], reg_0B[15:0]} !== {8'hFF, 16'd912}) $display("FAIL m2_sat got %h want ff / 0390", reg_0B); else n_pass++;
    endtask

    task automatic test_all_four();
        int v [4];
        v[0] = 'h0A5; v[1] = 'h3C8; v[2] = 'hFFF; v[3] = 'h123;
        for (int n = 0; n < 4; n++) tdata[n] = mk_good(v[n]);
        strobe(4'hF);
        idle(4);
        snap();
        for (int n = 0; n < 4; n++) begin
            n_chk++; if (get_reg(n)[17:0] !== {2'b01, 16'(period_of(v[n]))})
                $display("FAIL all4_m%0d got %h want %h", n, get_reg(n)[17:0], {2'b01, 16'(period_of(v[n]))}); else n_pass++;
        end
        n_chk++; if (reg_0D[19:16] !== 4'hF) $display("FAIL all4_valid got %h want f", reg_0D[19:16]); else n_pass++;
    endtask

    task automatic test_newest_wins();
        tdata[1] = mk_good('h010);
        strobe(4'b0010); idle(6);
        tdata[0] = mk_good('h111); tdata[1] = mk_good('h100);
        tdata[2] = mk_good('h222); tdata[3] = mk_good('h333);
        tlm_valid_i = 4'hF;
        @(posedge clk); #1;
        tdata[1] = mk_good('h207);
        tlm_valid_i = 4'b0010;
        @(posedge clk); #1;
        tlm_valid_i = '0;
        idle(8); snap();
        n_chk++; if ((reg_0A & ST_MASK) !== (32'h0001_000E & ST_MASK)) $display("FAIL newest_m1 got %h want 0001000e", reg_0A); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int base;
        base = exp_snaps;
        snap_req = 1'b1;
        @(posedge clk); #1;
        n_chk++; if ({snap_ack, reg_0D[15:0]} !== {1'b1, 16'(base + 1)})
            $display("FAIL b2b_first got %h want %h", {snap_ack, reg_0D[15:0]}, {1'b1, 16'(base + 1)}); else n_pass++;
        @(posedge clk); #1;
        snap_req = 1'b0;
        n_chk++; if ({snap_ack, reg_0D[15:0]} !== {1'b1, 16'(base + 2)})
            $display("FAIL b2b_second got %h want %h", {snap_ack, reg_0D[15:0]}, {1'b1, 16'(base + 2)}); else n_pass++;
        idle(1);
        n_chk++; if (snap_ack !== 1'b0) $display("FAIL b2b_ack_drop got %b want 0", snap_ack); else n_pass++;
        exp_snaps += 2;
    endtask

`ifdef MOTORS_TLM_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        tdata[3] = mk_good('h0A5);
        strobe(4'b1000);
        idle(50);
        snap_req = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (reg_0C[17:0] !== {2'b01, 16'd165}) $display("FAIL tmo_before got %h want %h", reg_0C[17:0], {2'b01, 16'd165}); else n_pass++;
        @(posedge clk); #1;
        snap_req = 1'b0;
        exp_snaps += 2;
        n_chk++; if (reg_0C[17:0] !== {2'b10, 16'd165}) $display("FAIL tmo_at got %h want %h", reg_0C[17:0], {2'b10, 16'd165}); else n_pass++;
        strobe(4'b1000); idle(5); snap();
        n_chk++; if (reg_0C[17:16] !== 2'b01) $display("FAIL tmo_clear got %b want 01", reg_0C[17:16]); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        for (int n = 0; n < 4; n++) tdata[n] = mk_good('h155 + n);
        strobe(4'hF);
        idle(1);
        rst = 1'b1;
        #2;
        for (int n = 0; n < 5; n++) begin
            n_chk++; if (get_reg(n) !== 32'h0) $display("FAIL midrst_reg%0d got %h want 00000000", n, get_reg(n)); else n_pass++;
        end
        n_chk++; if (snap_ack !== 1'b0) $display("FAIL midrst_ack got %b want 0", snap_ack); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; exp_snaps = 0;
        idle(8); snap();
        for (int n = 0; n < 4; n++) begin
            n_chk++; if (get_reg(n) !== 32'h0002_0000) $display("FAIL midrst_status%0d got %h want 00020000", n, get_reg(n)); else n_pass++;
        end
        n_chk++; if (reg_0D !== 32'h00F0_0001) $display("FAIL midrst_ctl got %h want 00f00001", reg_0D); else n_pass++;
    endtask

    task automatic test_random();
        int per [4]; int err [4]; int off [4]; int v [4];
        bit vld [4]; bit stl [4]; bit good [4];
        logic [3:0] m, sb, vb;
        logic [31:0] want;
        do_reset();
        for (int n = 0; n < 4; n++) begin per[n] = 0; err[n] = 0; vld[n] = 0; stl[n] = 1; end
        for (int r = 0; r < 40; r++) begin
            m = 4'($urandom_range(1, 15));
            for (int n = 0; n < 4; n++) begin
                off[n]  = $urandom_range(0, 2);
                v[n]    = $urandom_range(0, 4095);
                good[n] = ($urandom_range(0, 9) < 6);
            end
            for (int c = 0; c < 3; c++) begin
                tlm_valid_i = '0;
                for (int n = 0; n < 4; n++) begin
                    if (m[n] && off[n] == c) begin
                        tdata[n] = good[n] ? mk_good(v[n]) : (mk_good(v[n]) ^ 16'($urandom_range(1, 15)));
                        tlm_valid_i[n] = 1'b1;
                    end
                end
                @(posedge clk); #1;
            end
            tlm_valid_i = '0;
            for (int n = 0; n < 4; n++) begin
                if (m[n]) begin
                    if (good[n]) begin per[n] = period_of(v[n]); vld[n] = 1; stl[n] = 0; end
                    else if (err[n] < 255) err[n] = err[n] + 1;
                end
            end
            idle(6); snap();
            for (int n = 0; n < 4; n++) begin
                want = {8'(err[n]), 6'b0, stl[n], vld[n], 16'(per[n])};
                sb[n] = stl[n]; vb[n] = vld[n];
                n_chk++; if ((get_reg(n) & ST_MASK) !== (want & ST_MASK))
                    $display("FAIL rnd%0d_m%0d got %h want %h", r, n, get_reg(n), want); else n_pass++;
            end
            want = {8'h00, sb, vb, 16'(exp_snaps)};
            n_chk++; if ((reg_0D & CTL_MASK) !== (want & CTL_MASK))
                $display("FAIL rnd%0d_ctl got %h want %h", r, reg_0D, want); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_latency_m0();
        test_crc_err();
        test_all_four();
        test_newest_wins();
        test_back_to_back();
`ifdef MOTORS_TLM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
